// File: rtl/hsi_m_rx_sched.sv
// HSI master receive scheduler: one response reception per request, with timeouts and retries
// on the alternate redundant line. Optional per-line failure counters under HSI_RX_LINE_STATS_EN.
module hsi_m_rx_sched #(
  parameter int unsigned START_TMO = 256,
  parameter int unsigned FRAME_TMO = 4096,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned MAX_BYTES = 64,
  parameter int unsigned TMO_W     = 13
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clk_en,
  input  logic       start,
  input  logic       pref_src,
  input  logic       abort,
  input  logic       rx_start_bit_accepted,
  input  logic       q_rdy,
  input  logic       rx_frame_end,
  input  logic [5:0] rx_errs,
  output logic       dat_src,
  output logic       rx_busy,
  output logic       retry_req,
  output logic       done,
  output logic [1:0] status,
  output logic [5:0] errs_lat,
  output logic [6:0] byte_cnt,
  output logic [1:0] attempt
`ifdef HSI_RX_LINE_STATS_EN
  ,
  output logic [7:0] fail_cnt1,
  output logic [7:0] fail_cnt2
`endif
);

  localparam logic [TMO_W-1:0] StartLast = TMO_W'(START_TMO - 1);
  localparam logic [TMO_W-1:0] FrameLast = TMO_W'(FRAME_TMO - 1);
  localparam logic [6:0]       ByteLim   = 7'(MAX_BYTES);
  localparam logic [1:0]       RetryLim  = 2'(MAX_RETRY);

  localparam logic [1:0] CodeOk      = 2'd0;
  localparam logic [1:0] CodeTmo     = 2'd1;
  localparam logic [1:0] CodeRxErr   = 2'd2;
  localparam logic [1:0] CodeOverrun = 2'd3;

  typedef enum logic [2:0] {StIdle, StWaitSb, StRecv, StCheck, StFinish} state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             dat_src_q, dat_src_d;
  logic             busy_q, busy_d;
  logic             retry_q, retry_d;
  logic [1:0]       status_q, status_d;
  logic [5:0]       errs_q, errs_d;
  logic [6:0]       byte_q, byte_d;
  logic [1:0]       att_q, att_d;
  logic             ovr_q, ovr_d;
  logic             fail_ev;
  logic [1:0]       fail_code;
  logic             busy_state;

  assign busy_state = (state_q == StWaitSb) || (state_q == StRecv) || (state_q == StCheck);

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    dat_src_d = dat_src_q;
    busy_d    = busy_q;
    retry_d   = 1'b0;
    status_d  = status_q;
    errs_d    = errs_q;
    byte_d    = byte_q;
    att_d     = att_q;
    ovr_d     = ovr_q;
    fail_ev   = 1'b0;
    fail_code = CodeOk;

    // Abort outranks every other event, including a failure detected in the same cycle.
    if (abort && busy_state) begin
      state_d  = StFinish;
      status_d = CodeTmo;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d   = StWaitSb;
            dat_src_d = pref_src;
            att_d     = 2'd0;
            tmo_d     = '0;
            byte_d    = 7'd0;
            ovr_d     = 1'b0;
            busy_d    = 1'b1;
          end
        end
        StWaitSb: begin
          if (rx_start_bit_accepted) begin
            state_d = StRecv;
            tmo_d   = '0;
          end else if (clk_en) begin
            if (tmo_q == StartLast) begin
              fail_ev   = 1'b1;
              fail_code = CodeTmo;
            end else begin
              tmo_d = tmo_q + TMO_W'(1);
            end
          end
        end
        StRecv: begin
          if (q_rdy) begin
            if (byte_q != 7'd127) byte_d = byte_q + 7'd1;
            if (byte_q >= ByteLim) ovr_d = 1'b1;
          end
          if (rx_frame_end) begin
            state_d = StCheck;
          end else if (clk_en) begin
            if (tmo_q == FrameLast) begin
              fail_ev   = 1'b1;
              fail_code = CodeTmo;
            end else begin
              tmo_d = tmo_q + TMO_W'(1);
            end
          end
        end
        StCheck: begin
          errs_d = rx_errs;
          if (ovr_q) begin
            fail_ev   = 1'b1;
            fail_code = CodeOverrun;
          end else if (rx_errs != 6'd0) begin
            fail_ev   = 1'b1;
            fail_code = CodeRxErr;
          end else begin
            state_d  = StFinish;
            status_d = CodeOk;
          end
        end
        StFinish: state_d = StIdle;
        default:  state_d = StIdle;
      endcase

      if (fail_ev) begin
        if (att_q < RetryLim) begin
          state_d   = StWaitSb;
          att_d     = att_q + 2'd1;
          dat_src_d = ~dat_src_q;
          retry_d   = 1'b1;
          tmo_d     = '0;
          byte_d    = 7'd0;
          ovr_d     = 1'b0;
        end else begin
          state_d  = StFinish;
          status_d = fail_code;
        end
      end
    end

    if (state_d == StFinish) busy_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= StIdle;
      tmo_q     <= '0;
      dat_src_q <= 1'b1;
      busy_q    <= 1'b0;
      retry_q   <= 1'b0;
      status_q  <= 2'd0;
      errs_q    <= 6'd0;
      byte_q    <= 7'd0;
      att_q     <= 2'd0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      dat_src_q <= dat_src_d;
      busy_q    <= busy_d;
      retry_q   <= retry_d;
      status_q  <= status_d;
      errs_q    <= errs_d;
      byte_q    <= byte_d;
      att_q     <= att_d;
      ovr_q     <= ovr_d;
    end
  end

  assign dat_src   = dat_src_q;
  assign rx_busy   = busy_q;
  assign retry_req = retry_q;
  assign done      = (state_q == StFinish);
  assign status    = status_q;
  assign errs_lat  = errs_q;
  assign byte_cnt  = byte_q;
  assign attempt   = att_q;

`ifdef HSI_RX_LINE_STATS_EN
  logic [7:0] fc1_q, fc2_q;

  // Failures are charged to the line that was active when the attempt failed.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      fc1_q <= 8'd0;
      fc2_q <= 8'd0;
    end else if (fail_ev && !(abort && busy_state)) begin
      if (dat_src_q) begin
        if (fc1_q != 8'hff) fc1_q <= fc1_q + 8'd1;
      end else begin
        if (fc2_q != 8'hff) fc2_q <= fc2_q + 8'd1;
      end
    end
  end

  assign fail_cnt1 = fc1_q;
  assign fail_cnt2 = fc2_q;
`endif

endmodule

// File: tb/tb_hsi_m_rx_sched.sv
// Directed bench for hsi_m_rx_sched: inputs driven on the falling edge, outputs checked there too.
module tb_hsi_m_rx_sched;

  logic       clk = 1'b0;
  logic       n_rst, clk_en, start, pref_src, abort;
  logic       rx_start_bit_accepted, q_rdy, rx_frame_end;
  logic [5:0] rx_errs;
  logic       dat_src, rx_busy, retry_req, done;
  logic [1:0] status;
  logic [5:0] errs_lat;
  logic [6:0] byte_cnt;
  logic [1:0] attempt;

  int tests  = 0;
  int failed = 0;

  hsi_m_rx_sched dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clk_en               (clk_en),
    .start                (start),
    .pref_src             (pref_src),
    .abort                (abort),
    .rx_start_bit_accepted(rx_start_bit_accepted),
    .q_rdy                (q_rdy),
    .rx_frame_end         (rx_frame_end),
    .rx_errs              (rx_errs),
    .dat_src              (dat_src),
    .rx_busy              (rx_busy),
    .retry_req            (retry_req),
    .done                 (done),
    .status               (status),
    .errs_lat             (errs_lat),
    .byte_cnt             (byte_cnt),
    .attempt              (attempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic src);
    pref_src = src;
    start    = 1'b1;
    cyc();
    start    = 1'b0;
  endtask

  task automatic do_sb();
    rx_start_bit_accepted = 1'b1;
    cyc();
    rx_start_bit_accepted = 1'b0;
  endtask

  // Receives nb bytes, ends the frame, and returns just after the CHECK cycle.
  task automatic do_body(input int nb, input logic [5:0] e);
    if (nb > 0) begin
      q_rdy = 1'b1;
      cyc(nb);
      q_rdy = 1'b0;
    end
    rx_frame_end = 1'b1;
    cyc();
    rx_frame_end = 1'b0;
    check("done_early", done, 0);
    rx_errs = e;
    cyc();
    rx_errs = 6'd0;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_dat_src"}, dat_src, 1);
    check({pfx, "_busy"}, rx_busy, 0);
    check({pfx, "_retry"}, retry_req, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_status"}, status, 0);
    check({pfx, "_errs"}, errs_lat, 0);
    check({pfx, "_bytes"}, byte_cnt, 0);
    check({pfx, "_attempt"}, attempt, 0);
  endtask

  initial begin
    int   ticks, nretry;
    int   rt0, rt1;
    logic ds0, ds1;
    bit   got_done;

    n_rst = 1'b0; clk_en = 1'b1; start = 1'b0; pref_src = 1'b1; abort = 1'b0;
    rx_start_bit_accepted = 1'b0; q_rdy = 1'b0; rx_frame_end = 1'b0; rx_errs = 6'd0;
    cyc(2);
    check_reset_vals("rst");
    n_rst = 1'b1;
    cyc();

    // Clean frame on dat1: 10 ticks to start bit, 5 bytes.
    do_start(1'b1);
    check("t1_busy", rx_busy, 1);
    check("t1_dat_src", dat_src, 1);
    cyc(10);
    do_sb();
    do_body(5, 6'd0);
    check("t1_done", done, 1);
    check("t1_busy_low", rx_busy, 0);
    check("t1_status", status, 0);
    check("t1_bytes", byte_cnt, 5);
    check("t1_attempt", attempt, 0);
    check("t1_dat_src_end", dat_src, 1);
    cyc();
    check("t1_done_pulse", done, 0);

    // No start bit ever, clk_en at half rate: retries at 256/512 ticks, final timeout at 768.
    do_start(1'b1);
    ticks = 0; nretry = 0; rt0 = 0; rt1 = 0; ds0 = 1'b1; ds1 = 1'b0; got_done = 1'b0;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      clk_en = (i % 2 == 0);
      cyc();
      if (clk_en) ticks++;
      if (retry_req) begin
        if (nretry == 0) begin rt0 = ticks; ds0 = dat_src; end
        if (nretry == 1) begin rt1 = ticks; ds1 = dat_src; end
        nretry++;
      end
      if (done) got_done = 1'b1;
    end
    clk_en = 1'b1;
    check("t2_done_seen", got_done, 1);
    check("t2_nretry", nretry, 2);
    check("t2_retry0_tick", rt0, 256);
    check("t2_retry0_src", ds0, 0);
    check("t2_retry1_tick", rt1, 512);
    check("t2_retry1_src", ds1, 1);
    check("t2_done_tick", ticks, 768);
    check("t2_status", status, 1);
    check("t2_attempt", attempt, 2);
    check("t2_dat_src", dat_src, 1);
    cyc();

    // rx error on dat2 first, clean on the retry (dat1).
    do_start(1'b0);
    check("t3_dat_src0", dat_src, 0);
    do_sb();
    do_body(2, 6'b000100);
    check("t3_retry", retry_req, 1);
    check("t3_dat_src1", dat_src, 1);
    check("t3_attempt1", attempt, 1);
    check("t3_errs_mid", errs_lat, 6'b000100);
    check("t3_bytes_clr", byte_cnt, 0);
    check("t3_busy_mid", rx_busy, 1);
    cyc();
    check("t3_retry_pulse", retry_req, 0);
    do_sb();
    do_body(3, 6'd0);
    check("t3_done", done, 1);
    check("t3_status", status, 0);
    check("t3_errs", errs_lat, 0);
    check("t3_attempt", attempt, 1);
    check("t3_bytes", byte_cnt, 3);
    cyc();

    // Exactly MAX_BYTES bytes is not an overrun.
    do_start(1'b0);
    do_sb();
    do_body(64, 6'd0);
    check("t4a_done", done, 1);
    check("t4a_status", status, 0);
    check("t4a_bytes", byte_cnt, 64);
    check("t4a_dat_src", dat_src, 0);
    cyc();

    // 65 bytes on every attempt: overrun after three attempts.
    do_start(1'b1);
    for (int a = 0; a < 2; a++) begin
      do_sb();
      do_body(65, 6'd0);
      check("t4_retry", retry_req, 1);
    end
    do_sb();
    do_body(65, 6'b000001);
    check("t4_done", done, 1);
    check("t4_status", status, 3);
    check("t4_bytes", byte_cnt, 65);
    check("t4_attempt", attempt, 2);
    check("t4_dat_src", dat_src, 1);
    check("t4_errs", errs_lat, 6'b000001);
    cyc();

    // Start bit coinciding with the start-timeout expiry wins.
    do_start(1'b1);
    cyc(255);
    do_sb();
    check("t5_no_retry", retry_req, 0);
    check("t5_busy", rx_busy, 1);
    check("t5_attempt", attempt, 0);
    do_body(0, 6'd0);
    check("t5_done", done, 1);
    check("t5_status", status, 0);
    cyc();

    // Byte counter saturation, then abort with a simultaneous start.
    do_start(1'b1);
    do_sb();
    q_rdy = 1'b1;
    cyc(130);
    q_rdy = 1'b0;
    check("t6_sat", byte_cnt, 127);
    abort = 1'b1;
    start = 1'b1;
    cyc();
    abort = 1'b0;
    start = 1'b0;
    check("t6_done", done, 1);
    check("t6_status", status, 1);
    check("t6_busy", rx_busy, 0);
    cyc();
    check("t6_done_pulse", done, 0);
    check("t6_start_ignored", rx_busy, 0);

    // Reset mid-RECV, then a stray frame end must not complete anything.
    do_start(1'b0);
    do_sb();
    q_rdy = 1'b1;
    cyc(3);
    q_rdy = 1'b0;
    n_rst = 1'b0;
    cyc();
    n_rst = 1'b1;
    check_reset_vals("t7");
    rx_frame_end = 1'b1;
    cyc();
    rx_frame_end = 1'b0;
    got_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done) got_done = 1'b1;
      cyc();
    end
    check("t7_no_done", got_done, 0);
    check("t7_busy", rx_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
